instruction_sequencer: RTL and testbench

Cycle-level sequencer for the 8-bit CPU control path. It latches the opcode on each fetch cycle and classifies it into an addressing mode. It then steps through the addressing-mode address states (A0..A3) and the execution cycles, and tells the per-mode flag decoders and the execution decoder which mode and state are active. It sits between the memory/data-bus interface and the control-flag generators.

---
 rtl/instruction_sequencer_pkg.sv | 55 +++++
 rtl/instruction_sequencer_if.sv | 27 ++
 rtl/instruction_sequencer_decode.sv | 39 +++
 rtl/instruction_sequencer.sv | 84 ++++++++
 tb/tb_instruction_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared control-path definitions: phase/addressing-mode enums, address-state
// constants, per-mode address cycle counts and flag indices.
package control_pkg;

    localparam int unsigned ADDR_STATE_W = 4;
    localparam int unsigned EXEC_CYCLE_W = 3;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ADDR  = 2'd1,
        EXEC  = 2'd2
    } phase_t;

    typedef enum logic [3:0] {
        IMPLIED = 4'd0,
        IMM     = 4'd1,
        ZPG     = 4'd2,
        ZPG_X   = 4'd3,
        ZPG_Y   = 4'd4,
        ABS     = 4'd5,
        ABS_X   = 4'd6,
        ABS_Y   = 4'd7,
        IND_X   = 4'd8,
        IND_Y   = 4'd9
    } addr_mode_t;

    localparam logic [ADDR_STATE_W-1:0] A0 = 4'd0;
    localparam logic [ADDR_STATE_W-1:0] A1 = 4'd1;
    localparam logic [ADDR_STATE_W-1:0] A2 = 4'd2;
    localparam logic [ADDR_STATE_W-1:0] A3 = 4'd3;
    localparam logic [ADDR_STATE_W-1:0] A4 = 4'd4;
    localparam logic [ADDR_STATE_W-1:0] A5 = 4'd5;

    localparam int unsigned NUMFLAGS = 8;
    localparam int unsigned FLAG_C   = 0;
    localparam int unsigned FLAG_Z   = 1;
    localparam int unsigned FLAG_I   = 2;
    localparam int unsigned FLAG_D   = 3;
    localparam int unsigned FLAG_B   = 4;
    localparam int unsigned FLAG_U   = 5;
    localparam int unsigned FLAG_V   = 6;
    localparam int unsigned FLAG_N   = 7;

    // Number of address cycles before execution starts (indexed-absolute may skip one).
    function automatic logic [ADDR_STATE_W-1:0] addr_cycles(input addr_mode_t m);
        case (m)
            ZPG:                 addr_cycles = 4'd1;
            ZPG_X, ZPG_Y, ABS:   addr_cycles = 4'd2;
            ABS_X, ABS_Y:        addr_cycles = 4'd3;
            IND_X, IND_Y:        addr_cycles = 4'd4;
            default:             addr_cycles = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Bus between the memory/data interface and the instruction sequencer.
interface instruction_sequencer_if;
    import control_pkg::*;

    logic       ready;
    logic [7:0] data_in;
    logic       page_cross;
    logic       exec_done;

    phase_t                  phase;
    addr_mode_t              addr_mode;
    logic [ADDR_STATE_W-1:0] addr_state;
    logic [EXEC_CYCLE_W-1:0] exec_cycle;
    logic [7:0]              opcode;
    logic                    sync;
    logic                    exec_timeout;

    modport master (
        output ready, data_in, page_cross, exec_done,
        input  phase, addr_mode, addr_state, exec_cycle, opcode, sync, exec_timeout
    );

    modport slave (
        input  ready, data_in, page_cross, exec_done,
        output phase, addr_mode, addr_state, exec_cycle, opcode, sync, exec_timeout
    );
endinterface

// File: rtl/instruction_sequencer_decode.sv
// Combinational opcode -> addressing-mode classifier, shared with the flag muxes.
module opcode_mode_decode
    import control_pkg::*;
(
    input  logic [7:0] op,
    output addr_mode_t mode
);
    logic [2:0] bbb;
    logic [1:0] cc;

    assign bbb = op[4:2];
    assign cc  = op[1:0];

    always_comb begin
        mode = IMPLIED;
        if (cc == 2'b01) begin
            case (bbb)
                3'b000:  mode = IND_X;
                3'b001:  mode = ZPG;
                3'b010:  mode = IMM;
                3'b011:  mode = ABS;
                3'b100:  mode = IND_Y;
                3'b101:  mode = ZPG_X;
                3'b110:  mode = ABS_Y;
                default: mode = ABS_X;
            endcase
        end else if (cc != 2'b11) begin
            // LDX/STX use Y indexing where the rest of the group uses X
            case (bbb)
                3'b000:  mode = op[7] ? IMM : IMPLIED;
                3'b001:  mode = ZPG;
                3'b011:  mode = ABS;
                3'b101:  mode = (op == 8'h96 || op == 8'hB6) ? ZPG_Y : ZPG_X;
                3'b111:  mode = (op == 8'hBE) ? ABS_Y : ABS_X;
                default: mode = IMPLIED;
            endcase
        end
    end
endmodule

// File: rtl/instruction_sequencer.sv
// Fetch / address / execute sequencer: latches the opcode, walks the
// addressing-mode address states and the execution cycles with a watchdog.
module instruction_sequencer
    import control_pkg::*;
#(
    parameter int unsigned MAX_EXEC = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    instruction_sequencer_if.slave   bus
);
    addr_mode_t              dec_mode_c;
    logic [ADDR_STATE_W-1:0] addr_next_c;
    logic                    addr_last_c;
    logic                    skip_c;

    opcode_mode_decode u_decode (
        .op   (bus.data_in),
        .mode (dec_mode_c)
    );

    assign addr_next_c = bus.addr_state + 4'd1;
    assign addr_last_c = (addr_next_c == addr_cycles(bus.addr_mode));

    // Indexed absolute loads drop the fix-up cycle when no page was crossed
    assign skip_c = (bus.addr_mode == ABS_X || bus.addr_mode == ABS_Y)
                 && (bus.addr_state == A1) && !bus.page_cross
                 && (bus.opcode[7:5] != 3'b100);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.phase        <= FETCH;
            bus.sync         <= 1'b1;
            bus.opcode       <= 8'h00;
            bus.addr_mode    <= IMPLIED;
            bus.addr_state   <= A0;
            bus.exec_cycle   <= '0;
            bus.exec_timeout <= 1'b0;
        end else begin
            bus.exec_timeout <= 1'b0;
            if (bus.ready) begin
                case (bus.phase)
                    FETCH: begin
                        bus.opcode    <= bus.data_in;
                        bus.addr_mode <= dec_mode_c;
                        bus.sync      <= 1'b0;
                        bus.addr_state <= A0;
                        bus.exec_cycle <= '0;
                        bus.phase     <= (addr_cycles(dec_mode_c) != 4'd0) ? ADDR : EXEC;
                    end
                    ADDR: begin
                        if (addr_last_c || skip_c) begin
                            bus.phase      <= EXEC;
                            bus.addr_state <= A0;
                            bus.exec_cycle <= '0;
                        end else begin
                            bus.addr_state <= addr_next_c;
                        end
                    end
                    EXEC: begin
                        if (bus.exec_done) begin
                            bus.phase      <= FETCH;
                            bus.sync       <= 1'b1;
                            bus.exec_cycle <= '0;
                        end else if (bus.exec_cycle == EXEC_CYCLE_W'(MAX_EXEC)) begin
                            bus.phase        <= FETCH;
                            bus.sync         <= 1'b1;
                            bus.exec_cycle   <= '0;
                            bus.exec_timeout <= 1'b1;
                        end else begin
                            bus.exec_cycle <= bus.exec_cycle + 3'd1;
                        end
                    end
                    default: begin
                        bus.phase      <= FETCH;
                        bus.sync       <= 1'b1;
                        bus.addr_state <= A0;
                        bus.exec_cycle <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: directed instruction walks plus random traffic
// checked every cycle against an instruction-level reference model.
module tb_instruction_sequencer;
    localparam int MAXE = 7;

    logic clk = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    instruction_sequencer_if bus ();

    instruction_sequencer #(.MAX_EXEC(MAXE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int ncyc [10] = '{0, 0, 1, 2, 2, 2, 3, 3, 4, 4};
    int tab01 [8] = '{8, 2, 1, 5, 9, 3, 7, 6};

    function automatic int ref_mode(input int op);
        int b = (op >> 2) & 7;
        int c = op & 3;
        if (c == 1) return tab01[b];
        if (c == 3) return 0;
        if (op == 'h96 || op == 'hB6) return 4;
        if (op == 'hBE) return 7;
        if (b == 0) return (op >= 128) ? 1 : 0;
        if (b == 1) return 2;
        if (b == 3) return 5;
        if (b == 5) return 3;
        if (b == 7) return 6;
        return 0;
    endfunction

    // Address cycles actually taken, given what is known at address step 'idx'
    function automatic int eff_len(input int mode, input int op, input int idx, input bit pc);
        if ((mode == 6 || mode == 7) && idx == 1 && !pc && (op >> 5) != 4) return 2;
        return ncyc[mode];
    endfunction

    int m_ph, m_mode, m_op, m_ast, m_ec, m_to;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_mode <= 0; m_op <= 0; m_ast <= 0; m_ec <= 0; m_to <= 0;
        end else begin
            m_to <= 0;
            if (bus.ready) begin
                if (m_ph == 0) begin
                    m_op   <= int'(bus.data_in);
                    m_mode <= ref_mode(int'(bus.data_in));
                    m_ast  <= 0;
                    m_ec   <= 0;
                    m_ph   <= (ncyc[ref_mode(int'(bus.data_in))] > 0) ? 1 : 2;
                end else if (m_ph == 1) begin
                    if (m_ast + 1 >= eff_len(m_mode, m_op, m_ast, bus.page_cross)) begin
                        m_ph <= 2; m_ast <= 0; m_ec <= 0;
                    end else begin
                        m_ast <= m_ast + 1;
                    end
                end else begin
                    if (bus.exec_done) begin
                        m_ph <= 0; m_ec <= 0;
                    end else if (m_ec == MAXE) begin
                        m_ph <= 0; m_ec <= 0; m_to <= 1;
                    end else begin
                        m_ec <= m_ec + 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("phase",        int'(bus.phase),        m_ph);
            chk("addr_mode",    int'(bus.addr_mode),    m_mode);
            chk("addr_state",   int'(bus.addr_state),   (m_ph == 1) ? m_ast : 0);
            chk("exec_cycle",   int'(bus.exec_cycle),   (m_ph == 2) ? m_ec : 0);
            chk("opcode",       int'(bus.opcode),       m_op);
            chk("sync",         int'(bus.sync),         (m_ph == 0) ? 1 : 0);
            chk("exec_timeout", int'(bus.exec_timeout), m_to);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic r, input logic [7:0] d, input logic pc, input logic ed);
        bus.ready      = r;
        bus.data_in    = d;
        bus.page_cross = pc;
        bus.exec_done  = ed;
        @(negedge clk);
    endtask

    task automatic chk_st(input string name, input int ph, input int ast, input int ec);
        chk(name, int'(bus.phase) * 256 + int'(bus.addr_state) * 16 + int'(bus.exec_cycle),
            ph * 256 + ast * 16 + ec);
    endtask

    initial begin
        rst = 1'b1;
        bus.ready = 1'b0; bus.data_in = 8'h00; bus.page_cross = 1'b0; bus.exec_done = 1'b0;
        repeat (2) @(negedge clk);
        chk_st("reset_state", 0, 0, 0);
        chk("reset_sync", int'(bus.sync), 1);
        chk("reset_opcode", int'(bus.opcode), 0);
        chk("reset_mode", int'(bus.addr_mode), 0);
        chk("reset_timeout", int'(bus.exec_timeout), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // LDA abs
        step(1, 8'hAD, 0, 0); chk_st("AD_A0", 1, 0, 0); chk("AD_mode", int'(bus.addr_mode), 5);
        step(1, 8'h00, 0, 0); chk_st("AD_A1", 1, 1, 0);
        step(1, 8'h00, 0, 0); chk_st("AD_E0", 2, 0, 0);
        step(1, 8'h00, 0, 1); chk_st("AD_FETCH", 0, 0, 0); chk("AD_sync", int'(bus.sync), 1);

        // LDA abs,X without and with page crossing
        step(1, 8'hBD, 0, 0); step(1, 8'h00, 0, 0); chk_st("BD0_A1", 1, 1, 0);
        step(1, 8'h00, 0, 0); chk_st("BD0_skip_E0", 2, 0, 0);
        step(1, 8'h00, 0, 1);
        step(1, 8'hBD, 0, 0); step(1, 8'h00, 0, 0);
        step(1, 8'h00, 1, 0); chk_st("BD1_A2", 1, 2, 0);
        step(1, 8'h00, 0, 0); chk_st("BD1_E0", 2, 0, 0);
        step(1, 8'h00, 0, 1);

        // STA abs,X always takes A2
        step(1, 8'h9D, 0, 0); step(1, 8'h00, 0, 0);
        step(1, 8'h00, 0, 0); chk_st("9D_A2", 1, 2, 0);
        step(1, 8'h00, 0, 0); chk_st("9D_E0", 2, 0, 0);
        step(1, 8'h00, 0, 1);

        // LDA # goes straight to execution
        step(1, 8'hA9, 0, 0); chk_st("A9_E0", 2, 0, 0); chk("A9_mode", int'(bus.addr_mode), 1);
        step(1, 8'h00, 0, 1);

        // LDX zp,Y
        step(1, 8'hB6, 0, 0); chk("B6_mode", int'(bus.addr_mode), 4);
        step(1, 8'h00, 0, 0); chk_st("B6_A1", 1, 1, 0);
        step(1, 8'h00, 0, 0); chk_st("B6_E0", 2, 0, 0);
        step(1, 8'h00, 0, 1);

        // ORA (zp,X) stalled in A1
        step(1, 8'h01, 0, 0); step(1, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 1); chk_st("01_stall", 1, 1, 0);
        end
        step(1, 8'h00, 0, 0); chk_st("01_A2", 1, 2, 0);
        step(1, 8'h00, 0, 0); chk_st("01_A3", 1, 3, 0);
        step(1, 8'h00, 0, 0); chk_st("01_E0", 2, 0, 0);
        step(1, 8'h00, 0, 1);

        // NOP with no exec_done: watchdog
        step(1, 8'hEA, 0, 0); chk_st("EA_E0", 2, 0, 0);
        for (int i = 1; i <= MAXE; i++) begin
            step(1, 8'h00, 0, 0); chk_st("EA_Ecnt", 2, 0, i);
        end
        step(1, 8'h00, 0, 0); chk_st("EA_FETCH", 0, 0, 0); chk("EA_timeout", int'(bus.exec_timeout), 1);
        step(0, 8'h00, 0, 0); chk("EA_timeout_clr", int'(bus.exec_timeout), 0);

        // exec_done coinciding with the last cycle wins over the watchdog
        step(1, 8'hEA, 0, 0);
        for (int i = 1; i <= MAXE; i++) step(1, 8'h00, 0, 0);
        step(1, 8'h00, 0, 1); chk_st("EA_done_last", 0, 0, 0); chk("EA_no_timeout", int'(bus.exec_timeout), 0);

        // stalled exec_done is ignored
        step(1, 8'hEA, 0, 0); step(0, 8'h00, 0, 1); chk_st("EA_stall_done", 2, 0, 0);
        step(1, 8'h00, 0, 1);

        // asynchronous reset mid-instruction
        step(1, 8'hBD, 0, 0); step(1, 8'h00, 0, 0);
        #2 rst = 1'b1;
        #1 chk_st("async_rst_state", 0, 0, 0);
        chk("async_rst_opcode", int'(bus.opcode), 0);
        chk("async_rst_sync", int'(bus.sync), 1);
        @(negedge clk);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(299) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                step(($urandom_range(4) != 0), 8'($urandom), 1'($urandom), ($urandom_range(3) == 0));
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
